// File: rtl/awg_cmd_parser.sv
// ASCII command parser for the AWG: turns the UART RX byte stream into
// frequency/amplitude/phase/waveform settings, with range checks, nudge and sweep.
module awg_cmd_parser #(
    parameter int unsigned FREQ_W     = 16,
    parameter int unsigned AMP_W      = 3,
    parameter int unsigned PHASE_W    = 8,
    parameter int unsigned FREQ_DEF   = 1000,
    parameter int unsigned AMP_DEF    = 4,
    parameter int unsigned PHASE_DEF  = 0,
    parameter int unsigned FREQ_MIN   = 1,
    parameter int unsigned FREQ_MAX   = 20000,
    parameter int unsigned FREQ_STEP  = 100,
    parameter int unsigned MAX_DIGITS = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    input  logic               sweep_tick,
    output logic [FREQ_W-1:0]  freq,
    output logic [AMP_W-1:0]   amp,
    output logic [PHASE_W-1:0] phase,
    output logic [1:0]         wave_sel,
    output logic               sweep_en,
    output logic               cfg_update,
    output logic               err
);

    localparam int unsigned ACC_W   = $clog2(10 ** MAX_DIGITS);
    localparam int unsigned MUL_W   = ACC_W + 4;
    localparam int unsigned CNT_W   = $clog2(MAX_DIGITS + 1);
    localparam int unsigned AMP_LIM   = (32'd1 << AMP_W) - 32'd1;
    localparam int unsigned PHASE_LIM = (32'd1 << PHASE_W) - 32'd1;

    localparam logic [7:0] CH_CR    = 8'd13;
    localparam logic [7:0] CH_LF    = 8'd10;
    localparam logic [7:0] CH_PLUS  = 8'd43;
    localparam logic [7:0] CH_MINUS = 8'd45;
    localparam logic [7:0] CH_0     = 8'd48;
    localparam logic [7:0] CH_9     = 8'd57;
    localparam logic [7:0] CH_A     = 8'd65;
    localparam logic [7:0] CH_F     = 8'd70;
    localparam logic [7:0] CH_P     = 8'd80;
    localparam logic [7:0] CH_S     = 8'd83;
    localparam logic [7:0] CH_W     = 8'd87;
    localparam logic [7:0] CH_LA    = 8'd97;
    localparam logic [7:0] CH_LZ    = 8'd122;

    typedef enum logic [1:0] {S_IDLE, S_ARG, S_DISCARD} state_t;
    typedef enum logic [1:0] {K_F, K_A, K_P, K_W} key_t;

    state_t               state_q, state_d;
    key_t                 key_q, key_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [FREQ_W-1:0]    freq_q, freq_d;
    logic [AMP_W-1:0]     amp_q, amp_d;
    logic [PHASE_W-1:0]   phase_q, phase_d;
    logic [1:0]           wave_q, wave_d;
    logic                 sweep_q, sweep_d;
    logic                 cfg_q, cfg_d;
    logic                 err_q, err_d;

    // Input stage: byte and tick are registered so every effect lands one edge later
    logic [7:0]           byte_q;
    logic                 byte_v_q;
    logic                 tick_q;

    logic [7:0]           up;
    logic                 is_digit, is_term, is_key;
    key_t                 key_dec;
    logic [3:0]           digit_val;
    logic [MUL_W-1:0]     acc_mul;
    logic [31:0]          acc32, f32;
    logic                 f_cmd;

    assign freq       = freq_q;
    assign amp        = amp_q;
    assign phase      = phase_q;
    assign wave_sel   = wave_q;
    assign sweep_en   = sweep_q;
    assign cfg_update = cfg_q;
    assign err        = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_q   <= 8'd0;
            byte_v_q <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            byte_q   <= rx_data;
            byte_v_q <= rx_valid;
            tick_q   <= sweep_tick;
        end
    end

    // Byte classification (letters folded to upper case)
    always_comb begin
        up        = byte_q;
        is_key    = 1'b0;
        key_dec   = K_F;
        if (byte_q >= CH_LA && byte_q <= CH_LZ) begin
            up = byte_q - 8'd32;
        end
        is_digit  = (byte_q >= CH_0) && (byte_q <= CH_9);
        is_term   = (byte_q == CH_CR) || (byte_q == CH_LF);
        digit_val = 4'(byte_q - CH_0);
        case (up)
            CH_F:    begin is_key = 1'b1; key_dec = K_F; end
            CH_A:    begin is_key = 1'b1; key_dec = K_A; end
            CH_P:    begin is_key = 1'b1; key_dec = K_P; end
            CH_W:    begin is_key = 1'b1; key_dec = K_W; end
            default: begin is_key = 1'b0; key_dec = K_F; end
        endcase
        acc_mul = MUL_W'(acc_q) * MUL_W'(10) + MUL_W'(digit_val);
        acc32   = 32'(acc_q);
        f32     = 32'(freq_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            key_q   <= K_F;
            acc_q   <= '0;
            cnt_q   <= '0;
            freq_q  <= FREQ_W'(FREQ_DEF);
            amp_q   <= AMP_W'(AMP_DEF);
            phase_q <= PHASE_W'(PHASE_DEF);
            wave_q  <= 2'd0;
            sweep_q <= 1'b0;
            cfg_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            freq_q  <= freq_d;
            amp_q   <= amp_d;
            phase_q <= phase_d;
            wave_q  <= wave_d;
            sweep_q <= sweep_d;
            cfg_q   <= cfg_d;
            err_q   <= err_d;
        end
    end

    // Next-state and setting updates; f_cmd marks a frequency command that pre-empts a tick
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        freq_d  = freq_q;
        amp_d   = amp_q;
        phase_d = phase_q;
        wave_d  = wave_q;
        sweep_d = sweep_q;
        err_d   = 1'b0;
        cfg_d   = 1'b0;
        f_cmd   = 1'b0;

        if (byte_v_q) begin
            case (state_q)
                S_IDLE: begin
                    if (is_key) begin
                        state_d = S_ARG;
                        key_d   = key_dec;
                        acc_d   = '0;
                        cnt_d   = '0;
                    end else if (up == CH_PLUS) begin
                        f_cmd  = 1'b1;
                        freq_d = (f32 + FREQ_STEP > FREQ_MAX) ? FREQ_W'(FREQ_MAX)
                                                               : FREQ_W'(f32 + FREQ_STEP);
                    end else if (up == CH_MINUS) begin
                        f_cmd  = 1'b1;
                        freq_d = (f32 < FREQ_MIN + FREQ_STEP) ? FREQ_W'(FREQ_MIN)
                                                               : FREQ_W'(f32 - FREQ_STEP);
                    end else if (up == CH_S) begin
                        sweep_d = ~sweep_q;
                    end else if (!is_term) begin
                        err_d = 1'b1;
                    end
                end
                S_ARG: begin
                    if (is_digit) begin
                        if (32'(cnt_q) >= MAX_DIGITS) begin
                            err_d   = 1'b1;
                            state_d = S_DISCARD;
                        end else begin
                            acc_d = ACC_W'(acc_mul);
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else if (is_term) begin
                        state_d = S_IDLE;
                        if (cnt_q == '0) begin
                            err_d = 1'b1;
                        end else begin
                            case (key_q)
                                K_F: begin
                                    if (acc32 >= FREQ_MIN && acc32 <= FREQ_MAX) begin
                                        freq_d = FREQ_W'(acc_q);
                                        f_cmd  = 1'b1;
                                    end else begin
                                        err_d = 1'b1;
                                    end
                                end
                                K_A: begin
                                    if (acc32 <= AMP_LIM) amp_d = AMP_W'(acc_q);
                                    else                  err_d = 1'b1;
                                end
                                K_P: begin
                                    if (acc32 <= PHASE_LIM) phase_d = PHASE_W'(acc_q);
                                    else                    err_d = 1'b1;
                                end
                                default: begin
                                    if (acc32 <= 32'd3) wave_d = 2'(acc_q);
                                    else                err_d  = 1'b1;
                                end
                            endcase
                        end
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_DISCARD;
                    end
                end
                S_DISCARD: begin
                    if (is_term) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (tick_q && sweep_q && sweep_d && !f_cmd) begin
            freq_d = (f32 + FREQ_STEP > FREQ_MAX) ? FREQ_W'(FREQ_MIN)
                                                   : FREQ_W'(f32 + FREQ_STEP);
        end

        cfg_d = (freq_d != freq_q) || (amp_d != amp_q) || (phase_d != phase_q) ||
                (wave_d != wave_q) || (sweep_d != sweep_q);
    end

endmodule

// File: tb/tb_awg_cmd_parser.sv
// Directed testbench for awg_cmd_parser with hand-computed expectations.
module tb_awg_cmd_parser;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        sweep_tick;
    logic [15:0] freq;
    logic [2:0]  amp;
    logic [7:0]  phase;
    logic [1:0]  wave_sel;
    logic        sweep_en;
    logic        cfg_update;
    logic        err;

    int checks = 0;
    int errors = 0;
    int nc, ne;

    awg_cmd_parser dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .sweep_tick (sweep_tick),
        .freq       (freq),
        .amp        (amp),
        .phase      (phase),
        .wave_sel   (wave_sel),
        .sweep_en   (sweep_en),
        .cfg_update (cfg_update),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One byte, then one idle cycle; returns at the negedge where its effects are visible
    task automatic put(input logic [7:0] b, input logic tk);
        rx_data    = b;
        rx_valid   = 1'b1;
        sweep_tick = tk;
        @(negedge clk);
        rx_valid   = 1'b0;
        sweep_tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_str(input string s, output int n_cfg, output int n_err);
        n_cfg = 0;
        n_err = 0;
        for (int i = 0; i < s.len(); i++) begin
            put(s[i], 1'b0);
            n_cfg += int'(cfg_update);
            n_err += int'(err);
        end
    endtask

    task automatic tick();
        sweep_tick = 1'b1;
        @(negedge clk);
        sweep_tick = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst_n      = 1'b0;
        rx_data    = 8'd0;
        rx_valid   = 1'b0;
        sweep_tick = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_freq", 32'(freq), 1000);
        chk("rst_amp", 32'(amp), 4);
        chk("rst_phase", 32'(phase), 0);
        chk("rst_wave", 32'(wave_sel), 0);
        chk("rst_sweep", 32'(sweep_en), 0);
        chk("rst_cfg", 32'(cfg_update), 0);
        chk("rst_err", 32'(err), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // F2500 with exact terminator timing
        send_str("F2500", nc, ne);
        chk("f2500_prefix_err", 32'(ne), 0);
        rx_data  = 8'd13;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        chk("f2500_not_early", 32'(freq), 1000);
        @(negedge clk);
        chk("f2500_freq", 32'(freq), 2500);
        chk("f2500_cfg", 32'(cfg_update), 1);
        chk("f2500_err", 32'(err), 0);
        @(negedge clk);
        chk("f2500_cfg_one_cycle", 32'(cfg_update), 0);

        // Amplitude: lower-case key, then out-of-range
        send_str("a7\n", nc, ne);
        chk("a7_amp", 32'(amp), 7);
        chk("a7_cfg", 32'(nc), 1);
        chk("a7_err", 32'(ne), 0);
        send_str("A8\n", nc, ne);
        chk("a8_err", 32'(ne), 1);
        chk("a8_cfg", 32'(nc), 0);
        chk("a8_amp", 32'(amp), 7);

        // Too many digits, then phase
        send_str("F123456\r", nc, ne);
        chk("f6dig_err", 32'(ne), 1);
        chk("f6dig_freq", 32'(freq), 2500);
        send_str("P200\r", nc, ne);
        chk("p200_phase", 32'(phase), 200);
        chk("p200_err", 32'(ne), 0);

        // Nudge saturation
        send_str("F19950\r", nc, ne);
        chk("f19950", 32'(freq), 19950);
        send_str("+", nc, ne);
        chk("plus1_freq", 32'(freq), 20000);
        chk("plus1_cfg", 32'(nc), 1);
        send_str("+", nc, ne);
        chk("plus2_freq", 32'(freq), 20000);
        chk("plus2_cfg", 32'(nc), 0);
        send_str("-", nc, ne);
        chk("minus_freq", 32'(freq), 19900);

        // Sweep with wrap
        send_str("F19800\r", nc, ne);
        chk("f19800", 32'(freq), 19800);
        send_str("s", nc, ne);
        chk("sweep_on", 32'(sweep_en), 1);
        chk("sweep_on_cfg", 32'(nc), 1);
        tick();
        chk("tick1", 32'(freq), 19900);
        tick();
        chk("tick2", 32'(freq), 20000);
        tick();
        chk("tick3_wrap", 32'(freq), 1);

        // F commit beats a coincident tick
        send_str("F500", nc, ne);
        chk("f500_no_early", 32'(freq), 1);
        put(8'd13, 1'b1);
        chk("f500_tick_freq", 32'(freq), 500);
        chk("f500_tick_cfg", 32'(cfg_update), 1);
        @(negedge clk);
        chk("f500_tick_dropped", 32'(freq), 500);

        // Tick applied alongside a W commit
        send_str("W2", nc, ne);
        put(8'd13, 1'b1);
        chk("w2_wave", 32'(wave_sel), 2);
        chk("w2_tick_freq", 32'(freq), 600);

        // Disabling S drops the coincident tick
        put(8'd83, 1'b1);
        chk("s_off_sweep", 32'(sweep_en), 0);
        chk("s_off_freq", 32'(freq), 600);
        chk("s_off_cfg", 32'(cfg_update), 1);
        tick();
        chk("tick_sweep_off", 32'(freq), 600);

        // Rejected commands
        send_str("X", nc, ne);
        chk("x_err", 32'(ne), 1);
        chk("x_cfg", 32'(nc), 0);
        send_str("F\r", nc, ne);
        chk("f_empty_err", 32'(ne), 1);
        send_str("Fq\r", nc, ne);
        chk("fq_err", 32'(ne), 1);
        chk("fq_cfg", 32'(nc), 0);
        send_str("W4\r", nc, ne);
        chk("w4_err", 32'(ne), 1);
        chk("rej_freq", 32'(freq), 600);
        chk("rej_wave", 32'(wave_sel), 2);

        // Reset in the middle of a command
        send_str("F12", nc, ne);
        rst_n = 1'b0;
        #1;
        chk("midrst_freq", 32'(freq), 1000);
        chk("midrst_amp", 32'(amp), 4);
        chk("midrst_phase", 32'(phase), 0);
        chk("midrst_wave", 32'(wave_sel), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_str("3\r", nc, ne);
        chk("post_rst_err", 32'(ne), 1);
        chk("post_rst_cfg", 32'(nc), 0);
        chk("post_rst_freq", 32'(freq), 1000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
